// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the 3BC fetch sequencer.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_RUN,
      FETCH_HALT
   } fetch_state_t;

   localparam logic [8:0] kHALT_INSTR = 9'h1FF;

endpackage

// File: rtl/fetch_unit_lut_branch.sv
// Branch target ROM, table held inline as a combinational case.
// Only compiled when BRANCH_LUT_EN is defined.
`ifdef BRANCH_LUT_EN
module lut_branch #(
  parameter int LUT_IDX_W = 5,
  parameter int PC_W      = 10
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      entry
);

  always_comb begin
    case (int'(idx))
      0:       entry = PC_W'(0);
      1:       entry = PC_W'(16);
      2:       entry = PC_W'(64);
      3:       entry = PC_W'(200);
      4:       entry = PC_W'(256);
      5:       entry = PC_W'(300);
      6:       entry = PC_W'(400);
      7:       entry = PC_W'(512);
      default: entry = '0;
    endcase
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer for the 9-bit 3BC processor.
// Optional BRANCH_LUT_EN: Target indexes lut_branch instead of being used directly.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int LUT_IDX_W = 5,
   parameter int CNT_W     = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Jump,
   input  logic             Cond,
   input  logic             BranchRel,
   input  logic [PC_W-1:0]  Target,
   input  logic             Ack,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Done,
   output logic [CNT_W-1:0] InstrCnt
);

   fetch_state_t    state;
   logic [PC_W-1:0] branch_val;
   logic [PC_W-1:0] next_pc;

`ifdef BRANCH_LUT_EN
   logic unused_target_hi;

   assign unused_target_hi = ^Target[PC_W-1:LUT_IDX_W];

   lut_branch #(
      .LUT_IDX_W(LUT_IDX_W),
      .PC_W     (PC_W)
   ) u_lut_branch (
      .idx  (Target[LUT_IDX_W-1:0]),
      .entry(branch_val)
   );
`else
   localparam int unused_lut_idx_w = LUT_IDX_W;

   assign branch_val = Target;
`endif

   // Unsigned PC_W-bit add gives the signed-offset result modulo 2**PC_W.
   always_comb begin
      next_pc = ProgCtr + 1'b1;
      if (Jump && Cond) begin
         next_pc = BranchRel ? (ProgCtr + branch_val) : branch_val;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= FETCH_IDLE;
         ProgCtr  <= '0;
         Done     <= 1'b0;
         InstrCnt <= '0;
      end else if (Start) begin
         state    <= FETCH_IDLE;
         ProgCtr  <= '0;
         Done     <= 1'b0;
         InstrCnt <= '0;
      end else begin
         case (state)
            FETCH_IDLE: begin
               state <= FETCH_RUN;
            end
            FETCH_RUN: begin
               if (InstrCnt != '1) begin
                  InstrCnt <= InstrCnt + 1'b1;
               end
               if (Ack) begin
                  state <= FETCH_HALT;
                  Done  <= 1'b1;
               end else begin
                  ProgCtr <= next_pc;
               end
            end
            FETCH_HALT: begin
               Done <= 1'b1;
            end
            default: begin
               state <= FETCH_IDLE;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (default build, BRANCH_LUT_EN undefined).
module tb_fetch_unit;

   localparam int PC_W  = 10;
   localparam int CNT_W = 16;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             Clk;
   logic             Reset;
   logic             Start;
   logic             Jump;
   logic             Cond;
   logic             BranchRel;
   logic [PC_W-1:0]  Target;
   logic             Ack;
   logic [PC_W-1:0]  ProgCtr;
   logic             Done;
   logic [CNT_W-1:0] InstrCnt;

   int checks;
   int failures;

   // reference model: mode 0 = idle, 1 = running, 2 = halted
   int m_mode;
   int m_pc;
   int m_cnt;

   fetch_unit #(
      .PC_W     (PC_W),
      .LUT_IDX_W(5),
      .CNT_W    (CNT_W)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Jump     (Jump),
      .Cond     (Cond),
      .BranchRel(BranchRel),
      .Target   (Target),
      .Ack      (Ack),
      .ProgCtr  (ProgCtr),
      .Done     (Done),
      .InstrCnt (InstrCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic model_clear();
      m_mode = 0;
      m_pc   = 0;
      m_cnt  = 0;
   endtask

   // Advance the model by the rules for one edge, then clock the DUT.
   task automatic tick();
      int off;
      if (Start) begin
         model_clear();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         if (Ack) begin
            m_mode = 2;
         end else if (Jump && Cond) begin
            if (BranchRel) begin
               off  = int'(Target);
               if (off >= PC_MOD / 2) off = off - PC_MOD;
               m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
            end else begin
               m_pc = int'(Target);
            end
         end else begin
            m_pc = (m_pc + 1) % PC_MOD;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      Start = 1'b0; Jump = 1'b0; Cond = 1'b0; BranchRel = 1'b0;
      Target = '0; Ack = 1'b0;
   endtask

   task automatic start_run();
      idle_inputs();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
   endtask

   task automatic jump_abs(input int t);
      Jump = 1'b1; Cond = 1'b1; BranchRel = 1'b0; Target = PC_W'(t);
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      Reset = 1'b1;
      model_clear();
      #12;
      checks++;
      if ({ProgCtr, Done, InstrCnt} !== {PC_W'(0), 1'b0, CNT_W'(0)}) begin
         failures++;
         $display("FAIL reset_state: pc=%0d done=%0b cnt=%0d required pc=0 done=0 cnt=0",
                  ProgCtr, Done, InstrCnt);
      end
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_sequential();
      idle_inputs();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         tick();
         checks++;
         if (ProgCtr !== PC_W'(i) || InstrCnt !== CNT_W'(i) || Done !== 1'b0) begin
            failures++;
            $display("FAIL seq_step%0d: pc=%0d cnt=%0d done=%0b required pc=%0d cnt=%0d done=0",
                     i, ProgCtr, InstrCnt, Done, i, i);
         end
      end
   endtask

   task automatic test_branch();
      start_run();
      jump_abs(20);
      Jump = 1'b1; Cond = 1'b1; BranchRel = 1'b1; Target = 10'h3FD;
      tick();
      checks++;
      if (ProgCtr !== 10'd17) begin
         failures++;
         $display("FAIL branch_rel_taken: pc=%0d required 17", ProgCtr);
      end
      jump_abs(20);
      Jump = 1'b1; Cond = 1'b0; BranchRel = 1'b1; Target = 10'h3FD;
      tick();
      checks++;
      if (ProgCtr !== 10'd21) begin
         failures++;
         $display("FAIL branch_cond0: pc=%0d required 21", ProgCtr);
      end
      jump_abs(100);
      checks++;
      if (ProgCtr !== 10'd100) begin
         failures++;
         $display("FAIL branch_abs: pc=%0d required 100", ProgCtr);
      end
   endtask

   task automatic test_wrap();
      start_run();
      jump_abs(1023);
      tick();
      checks++;
      if (ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL wrap_inc: pc=%0d required 0", ProgCtr);
      end
      jump_abs(2);
      Jump = 1'b1; Cond = 1'b1; BranchRel = 1'b1; Target = 10'h3FB;
      tick();
      idle_inputs();
      checks++;
      if (ProgCtr !== 10'd1021) begin
         failures++;
         $display("FAIL wrap_rel_neg: pc=%0d required 1021", ProgCtr);
      end
   endtask

   task automatic test_halt();
      logic [CNT_W-1:0] cnt_at_halt;
      start_run();
      jump_abs(50);
      Ack = 1'b1; Jump = 1'b1; Cond = 1'b1; BranchRel = 1'b0; Target = 10'd7;
      tick();
      cnt_at_halt = CNT_W'(m_cnt);
      checks++;
      if (ProgCtr !== 10'd50 || Done !== 1'b1 || InstrCnt !== CNT_W'(m_cnt)) begin
         failures++;
         $display("FAIL halt_entry: pc=%0d done=%0b cnt=%0d required pc=50 done=1 cnt=%0d",
                  ProgCtr, Done, InstrCnt, m_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         Jump = 1'($urandom); Cond = 1'b1; Ack = 1'($urandom);
         BranchRel = 1'($urandom); Target = PC_W'($urandom);
         tick();
         checks++;
         if (ProgCtr !== 10'd50 || Done !== 1'b1 || InstrCnt !== cnt_at_halt) begin
            failures++;
            $display("FAIL halt_frozen%0d: pc=%0d done=%0b cnt=%0d required pc=50 done=1 cnt=%0d",
                     i, ProgCtr, Done, InstrCnt, cnt_at_halt);
         end
      end
      idle_inputs();
      Start = 1'b1;
      tick();
      checks++;
      if ({ProgCtr, Done, InstrCnt} !== {PC_W'(0), 1'b0, CNT_W'(0)}) begin
         failures++;
         $display("FAIL halt_restart: pc=%0d done=%0b cnt=%0d required pc=0 done=0 cnt=0",
                  ProgCtr, Done, InstrCnt);
      end
      Start = 1'b0;
   endtask

   task automatic test_async_reset();
      start_run();
      jump_abs(37);
      checks++;
      if (ProgCtr !== 10'd37) begin
         failures++;
         $display("FAIL areset_setup: pc=%0d required 37", ProgCtr);
      end
      #2;
      Reset = 1'b1;
      model_clear();
      #1;
      checks++;
      if ({ProgCtr, Done, InstrCnt} !== {PC_W'(0), 1'b0, CNT_W'(0)}) begin
         failures++;
         $display("FAIL areset_async: pc=%0d done=%0b cnt=%0d required pc=0 done=0 cnt=0",
                  ProgCtr, Done, InstrCnt);
      end
      #1;
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      m_mode = 1;
   endtask

   task automatic test_saturation();
      start_run();
      for (int i = 0; i < CNT_MAX + 4; i++) tick();
      checks++;
      if (InstrCnt !== '1) begin
         failures++;
         $display("FAIL cnt_saturate: cnt=%0d required %0d", InstrCnt, CNT_MAX);
      end
      Ack = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (InstrCnt !== '1 || Done !== 1'b1) begin
         failures++;
         $display("FAIL cnt_saturate_ack: cnt=%0d done=%0b required cnt=%0d done=1",
                  InstrCnt, Done, CNT_MAX);
      end
   endtask

   task automatic test_random();
      start_run();
      for (int i = 0; i < 400; i++) begin
         Start     = ($urandom_range(0, 49) == 0);
         Ack       = ($urandom_range(0, 29) == 0);
         Jump      = 1'($urandom);
         Cond      = 1'($urandom);
         BranchRel = 1'($urandom);
         Target    = PC_W'($urandom);
         tick();
         checks++;
         if (ProgCtr !== PC_W'(m_pc) || InstrCnt !== CNT_W'(m_cnt) || Done !== (m_mode == 2)) begin
            failures++;
            $display("FAIL random_cyc%0d: pc=%0d done=%0b cnt=%0d required pc=%0d done=%0b cnt=%0d",
                     i, ProgCtr, Done, InstrCnt, m_pc, (m_mode == 2), m_cnt);
         end
      end
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Reset    = 1'b0;
      idle_inputs();
      model_clear();
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_halt();
      test_async_reset();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
